mips_hilo_ctrl: RTL and testbench

Sequencer for the ALU's iterative multiply/divide path and owner of the architectural HI/LO registers. Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the decode stage and drives the ALU mode_mult/mode_div/complement controls and operands. Holds the operands stable until multdiv_ready, then captures product or quotient/remainder into HI/LO. Stalls the pipeline on HI/LO hazards and supports flush (exception) abort.

---
 rtl/mips_hilo_ctrl_pkg.sv | 30 +++
 rtl/mips_busy_watchdog.sv | 45 ++++
 rtl/mips_hilo_ctrl.sv | 144 ++++++++++++++
 tb/tb_mips_hilo_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_hilo_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package mips_hilo_ctrl_pkg;

  // Decode-stage op codes for HI/LO-class instructions.
  localparam logic [2:0] HILO_MULT  = 3'd0;
  localparam logic [2:0] HILO_MULTU = 3'd1;
  localparam logic [2:0] HILO_DIV   = 3'd2;
  localparam logic [2:0] HILO_DIVU  = 3'd3;
  localparam logic [2:0] HILO_MFHI  = 3'd4;
  localparam logic [2:0] HILO_MFLO  = 3'd5;
  localparam logic [2:0] HILO_MTHI  = 3'd6;
  localparam logic [2:0] HILO_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } hilo_state_e;

  // Ops 0..3 run on the iterative ALU path; 4..7 only touch HI/LO.
  function automatic logic hilo_is_muldiv(input logic [2:0] op);
    return ~op[2];
  endfunction

  // MULT and DIV treat operands as two's complement.
  function automatic logic hilo_is_signed(input logic [2:0] op);
    return (op == HILO_MULT) || (op == HILO_DIV);
  endfunction

endpackage

// File: rtl/mips_busy_watchdog.sv
// Counts BUSY cycles and raises a sticky flag once the count reaches TIMEOUT.
module mips_busy_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic active,
  output logic timeout_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // Next count: clear on a new op, otherwise count BUSY cycles and saturate.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (start) begin
      cnt_d = '0;
    end else if (active && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_d == CntMax) begin
      err_d = 1'b1;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/mips_hilo_ctrl.sv
// HI/LO owner and sequencer for the iterative multiply/divide ALU path.
module mips_hilo_ctrl
  import mips_hilo_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 64,
  parameter logic [31:0] HILO_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic        flush,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        stall,
  output logic [31:0] hilo_rdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        timeout_err,
  output logic        alu_mode_mult,
  output logic        alu_mode_div,
  output logic        alu_acompl,
  output logic        alu_bcompl,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic        alu_ready,
  input  logic [31:0] alu_quotient,
  input  logic [31:0] alu_remainder,
  input  logic [63:0] alu_product
);

  hilo_state_e state_q, state_d;
  logic        is_div_q, is_div_d;
  logic        acompl_q, acompl_d;
  logic        bcompl_q, bcompl_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        accept;
  logic        issue;

  assign accept = op_valid & ~flush & (state_q == ST_IDLE);
  assign issue  = accept & hilo_is_muldiv(op_code);

  // Next-state, operand latch and HI/LO write decode.
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    acompl_d = acompl_q;
    bcompl_d = bcompl_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (issue) begin
          state_d  = ST_BUSY;
          is_div_d = op_code[1];
          acompl_d = hilo_is_signed(op_code) & rs_val[31];
          bcompl_d = hilo_is_signed(op_code) & rt_val[31];
          a_d      = rs_val;
          b_d      = rt_val;
        end else if (accept && (op_code == HILO_MTHI)) begin
          hi_d = rs_val;
        end else if (accept && (op_code == HILO_MTLO)) begin
          lo_d = rs_val;
        end
      end
      ST_BUSY: begin
        // Flush beats a coincident ready so an aborted op never commits.
        if (flush) begin
          state_d = ST_DRAIN;
        end else if (alu_ready) begin
          state_d = ST_IDLE;
          if (is_div_q) begin
            hi_d = alu_remainder;
            lo_d = alu_quotient;
          end else begin
            hi_d = alu_product[63:32];
            lo_d = alu_product[31:0];
          end
        end
      end
      ST_DRAIN: begin
        // One cycle with modes low lets the ALU fall back to its idle state.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, operand and HI/LO registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      is_div_q <= 1'b0;
      acompl_q <= 1'b0;
      bcompl_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= HILO_RST;
      lo_q     <= HILO_RST;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      acompl_q <= acompl_d;
      bcompl_q <= bcompl_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  mips_busy_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .start      (issue),
    .active     (state_q == ST_BUSY),
    .timeout_err(timeout_err)
  );

  // Modes come straight from registered state so they cannot glitch.
  assign alu_mode_mult = (state_q == ST_BUSY) & ~is_div_q;
  assign alu_mode_div  = (state_q == ST_BUSY) & is_div_q;
  assign alu_acompl    = acompl_q;
  assign alu_bcompl    = bcompl_q;
  assign alu_a         = a_q;
  assign alu_b         = b_q;

  assign stall      = op_valid & ~flush & (state_q != ST_IDLE);
  assign hilo_rdata = (op_code == HILO_MFHI) ? hi_q : lo_q;
  assign hi         = hi_q;
  assign lo         = lo_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_hilo_ctrl.sv
// Self-checking bench for mips_hilo_ctrl with a behavioural ALU stub.
module tb_mips_hilo_ctrl;
  import mips_hilo_ctrl_pkg::*;

  localparam int unsigned TO  = 20;
  localparam logic [31:0] RST = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic [2:0]  op_code;
  logic        flush;
  logic [31:0] rs_val, rt_val;
  logic        stall;
  logic [31:0] hilo_rdata, hi, lo;
  logic        busy, timeout_err;
  logic        alu_mode_mult, alu_mode_div, alu_acompl, alu_bcompl;
  logic [31:0] alu_a, alu_b;
  logic        alu_ready;
  logic [31:0] alu_quotient, alu_remainder;
  logic [63:0] alu_product;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;
  logic        hang;

  always #5 clk = ~clk;

  mips_hilo_ctrl #(
    .TIMEOUT (TO),
    .HILO_RST(RST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_code      (op_code),
    .flush        (flush),
    .rs_val       (rs_val),
    .rt_val       (rt_val),
    .stall        (stall),
    .hilo_rdata   (hilo_rdata),
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .alu_mode_mult(alu_mode_mult),
    .alu_mode_div (alu_mode_div),
    .alu_acompl   (alu_acompl),
    .alu_bcompl   (alu_bcompl),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ready    (alu_ready),
    .alu_quotient (alu_quotient),
    .alu_remainder(alu_remainder),
    .alu_product  (alu_product)
  );

  // ALU stub: sign/magnitude datapath, ready after 4 (mult) or 17 (div) mode cycles.
  logic [4:0]  alu_cnt;
  logic [31:0] ma, mb, sq, sr;
  logic [63:0] sp;

  always @(posedge clk or negedge rst) begin
    if (!rst) alu_cnt <= '0;
    else if (alu_mode_mult || alu_mode_div) alu_cnt <= alu_cnt + 5'd1;
    else alu_cnt <= '0;
  end

  assign alu_ready = !hang && ((alu_mode_mult && alu_cnt == 5'd3) ||
                               (alu_mode_div && alu_cnt == 5'd16));

  always_comb begin
    ma = alu_acompl ? (~alu_a + 32'd1) : alu_a;
    mb = alu_bcompl ? (~alu_b + 32'd1) : alu_b;
    sp = {32'd0, ma} * {32'd0, mb};
    if (mb == 32'd0) begin
      sq = 32'hFFFF_FFFF;
      sr = ma;
    end else begin
      sq = ma / mb;
      sr = ma % mb;
    end
    alu_product   = (alu_acompl ^ alu_bcompl) ? (~sp + 64'd1) : sp;
    alu_quotient  = (alu_acompl ^ alu_bcompl) ? (~sq + 32'd1) : sq;
    alu_remainder = alu_acompl ? (~sr + 32'd1) : sr;
  end

  // Architectural reference: returns {hi, lo} for a mult/div op.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    if (op == HILO_MULT || op == HILO_DIV) begin
      sa = $signed({{32{a[31]}}, a});
      sb = $signed({{32{b[31]}}, b});
    end else begin
      sa = $signed({32'd0, a});
      sb = $signed({32'd0, b});
    end
    if (!op[1]) return sa * sb;
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE and check its full effect, including exact latency.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
    int  lat;
    logic sgn;
    op_valid = 1'b1;
    op_code  = op;
    rs_val   = a;
    rt_val   = b;
    #1;
    chk("stall_idle", 64'(stall), 64'd0);
    if (op == HILO_MFHI) chk("rdata_mfhi", 64'(hilo_rdata), 64'(eh));
    if (op == HILO_MFLO) chk("rdata_mflo", 64'(hilo_rdata), 64'(el));
    step();
    op_valid = 1'b0;
    rs_val   = $urandom;
    rt_val   = $urandom;
    if (!op[2]) begin
      lat = op[1] ? 17 : 4;
      sgn = (op == HILO_MULT) || (op == HILO_DIV);
      for (int i = 0; i < lat; i++) begin
        chk("busy", 64'(busy), 64'd1);
        chk("mode_mult", 64'(alu_mode_mult), 64'(!op[1]));
        chk("mode_div", 64'(alu_mode_div), 64'(op[1]));
        chk("acompl", 64'(alu_acompl), 64'(sgn & a[31]));
        chk("bcompl", 64'(alu_bcompl), 64'(sgn & b[31]));
        chk("alu_a", 64'(alu_a), 64'(a));
        chk("alu_b", 64'(alu_b), 64'(b));
        chk("hi_held", 64'(hi), 64'(m_hi));
        step();
      end
      chk("mode_off", 64'({alu_mode_mult, alu_mode_div}), 64'd0);
    end
    chk("busy_done", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    m_hi = eh;
    m_lo = el;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [63:0] r;
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          cyc;
    bit          done;

    vecs[0]  = '{HILO_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1]  = '{HILO_DIVU,  32'd100,       32'd7,        32'd2,         32'd14};
    vecs[2]  = '{HILO_MTHI,  32'h1234,      32'd0,        32'h1234,      32'd14};
    vecs[3]  = '{HILO_MFHI,  32'd0,         32'd0,        32'h1234,      32'd14};
    vecs[4]  = '{HILO_MTLO,  32'h5678,      32'd0,        32'h1234,      32'h5678};
    vecs[5]  = '{HILO_MFLO,  32'd0,         32'd0,        32'h1234,      32'h5678};
    vecs[6]  = '{HILO_DIV,   32'hFFFF_FF9C, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFF2};
    vecs[7]  = '{HILO_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[8]  = '{HILO_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        32'd1};
    vecs[9]  = '{HILO_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2};
    vecs[10] = '{HILO_DIVU,  32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF};
    vecs[11] = '{HILO_DIVU,  32'h8000_0000, 32'd3,        32'd2,         32'h2AAA_AAAA};
    vecs[12] = '{HILO_MFHI,  32'd0,         32'd0,        32'd2,         32'h2AAA_AAAA};

    hang = 1'b0; op_valid = 1'b0; op_code = '0; flush = 1'b0; rs_val = '0; rt_val = '0;
    rst = 1'b0;
    #12;
    chk("rst_hi", 64'(hi), 64'(RST));
    chk("rst_lo", 64'(lo), 64'(RST));
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_alu", {alu_a, alu_b}, 64'd0);
    chk("rst_flags", 64'({alu_mode_mult, alu_mode_div, alu_acompl, alu_bcompl, timeout_err}),
        64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    m_hi = RST;
    m_lo = RST;

    // Directed vector table.
    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].hi, vecs[i].lo);
    end
    chk("no_timeout", 64'(timeout_err), 64'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      if (i % 4 == 0) b = 32'($urandom_range(0, 9));
      if (op[1] && !op[2] && b == 32'd0) b = 32'd1;
      eh = m_hi;
      el = m_lo;
      if (!op[2]) begin
        r  = ref_result(op, a, b);
        eh = r[63:32];
        el = r[31:0];
      end else if (op == HILO_MTHI) begin
        eh = a;
      end else if (op == HILO_MTLO) begin
        el = a;
      end
      do_op(op, a, b, eh, el);
    end

    // Ops presented while a divide runs are stalled; MFLO then sees the quotient.
    a = 32'd1000;
    b = 32'd33;
    r = ref_result(HILO_DIV, a, b);
    op_valid = 1'b1; op_code = HILO_DIV; rs_val = a; rt_val = b;
    step();
    cyc = 0;
    done = 0;
    while (!done && cyc < 40) begin
      op_code = (cyc % 3 == 0) ? HILO_MTHI : (cyc % 3 == 1) ? HILO_MULTU : HILO_MFLO;
      rs_val = $urandom;
      #1;
      if (busy) begin
        chk("stall_busy", 64'(stall), 64'd1);
        chk("hi_no_mthi", 64'(hi), 64'(m_hi));
        step();
        cyc++;
      end else begin
        op_code = HILO_MFLO;
        #1;
        chk("stall_released", 64'(stall), 64'd0);
        chk("rdata_quot", 64'(hilo_rdata), 64'(r[31:0]));
        done = 1;
      end
    end
    if (!done) chk("stall_wait_bound", 64'd0, 64'd1);
    chk("div_busy_cycles", 64'(cyc), 64'd17);
    step();
    op_valid = 1'b0;
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk("hi_after_div", 64'(hi), 64'(m_hi));

    // Flush five cycles into a divide: drain one cycle, HI/LO untouched.
    do_op(HILO_MTHI, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, m_lo);
    do_op(HILO_MTLO, 32'hA5A5_A5A5, 32'd0, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    op_valid = 1'b1; op_code = HILO_DIV; rs_val = 32'd1000; rt_val = 32'd3;
    step();
    op_valid = 1'b0;
    repeat (4) step();
    flush = 1'b1; op_valid = 1'b1; op_code = HILO_MTHI; rs_val = 32'd0;
    #1;
    chk("stall_flush", 64'(stall), 64'd0);
    step();
    flush = 1'b0; op_valid = 1'b0;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_modes", 64'({alu_mode_mult, alu_mode_div}), 64'd0);
    chk("drain_hilo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk("drain_exit", 64'(busy), 64'd0);
    chk("flush_hilo", {hi, lo}, 64'hA5A5_A5A5_A5A5_A5A5);
    do_op(HILO_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);

    // Flush in IDLE kills an MTLO.
    flush = 1'b1; op_valid = 1'b1; op_code = HILO_MTLO; rs_val = 32'h1234;
    step();
    flush = 1'b0; op_valid = 1'b0;
    chk("idle_flush_lo", 64'(lo), 64'd6);

    // Flush coincident with alu_ready.
    op_valid = 1'b1; op_code = HILO_MULT; rs_val = 32'd5; rt_val = 32'd6;
    step();
    op_valid = 1'b0;
    repeat (3) step();
    flush = 1'b1;
    #1;
    chk("ready_seen", 64'(alu_ready), 64'd1);
    step();
    flush = 1'b0;
    chk("ready_flush_drain", 64'(busy), 64'd1);
    chk("ready_flush_modes", 64'({alu_mode_mult, alu_mode_div}), 64'd0);
    chk("ready_flush_hilo", {hi, lo}, {32'd0, 32'd6});
    step();
    chk("ready_flush_idle", 64'(busy), 64'd0);

    // Watchdog with an ALU that never completes.
    hang = 1'b1;
    op_valid = 1'b1; op_code = HILO_MULT; rs_val = 32'd7; rt_val = 32'd9;
    step();
    op_valid = 1'b0;
    repeat (19) step();
    chk("wd_before", 64'(timeout_err), 64'd0);
    chk("wd_busy", 64'(busy), 64'd1);
    step();
    chk("wd_set", 64'(timeout_err), 64'd1);
    repeat (5) step();
    chk("wd_wait", 64'({busy, timeout_err}), 64'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    hang  = 1'b0;
    step();
    chk("wd_sticky", 64'({busy, timeout_err}), 64'd1);
    do_op(HILO_MULTU, 32'd4, 32'd5, 32'd0, 32'd20);
    chk("wd_sticky2", 64'(timeout_err), 64'd1);

    // Asynchronous reset in the middle of a multiply.
    do_op(HILO_MTHI, 32'h77, 32'd0, 32'h77, 32'd20);
    op_valid = 1'b1; op_code = HILO_MULT; rs_val = 32'hFFFF_FFF0; rt_val = 32'hFFFF_FFF1;
    step();
    op_valid = 1'b0;
    step();
    #3;
    rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_hilo", {hi, lo}, {RST, RST});
    chk("arst_alu", {alu_a, alu_b}, 64'd0);
    chk("arst_flags", 64'({alu_mode_mult, alu_mode_div, alu_acompl, alu_bcompl, timeout_err}),
        64'd0);
    @(negedge clk);
    rst = 1'b1;
    step();
    m_hi = RST;
    m_lo = RST;
    do_op(HILO_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
